// File: rtl/pp_ring.sv
// -----------------------------------------------------------------------------
// pp_ring -- N-page frame ring buffer.
//
// The write side fills the current write page byte by byte and commits it with
// a one-cycle switch pulse, which captures the page's flags and length. The
// read side sees the oldest committed page combinationally and releases it
// with rd_done. One page is always reserved for writing, so at most
// N_PAGES-1 pages are pending and the write page never aliases a read page.
//
// Parameters
//   N_WIDTH  log2 of the page count (N_PAGES = 2**N_WIDTH, at least 2)
//   PAGE_AW  byte address width within a page (page size 2**PAGE_AW bytes)
//   HIGH_WM  pending-page count at which high_wm is raised
//
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   wr_byte        write data, stored at {wr_ptr, wr_addr} when wr_clk is high
//   wr_addr        byte address within the write page
//   wr_clk         one-cycle write strobe
//   wr_flags       flags captured with the page on a successful switch
//   switch         commit the write page
//   wr_abort       discard the write page length (beats a same-cycle switch)
//   rd_addr        byte address within the oldest committed page
//   rd_byte        combinational read data of the oldest committed page
//   rd_flags       flags of the oldest committed page
//   rd_len         captured length of the oldest committed page
//   rd_done        release the oldest committed page
//   rd_done_all    flush every committed page and the write page
//   unread         at least one committed page is pending
//   pend_cnt       number of committed, unreleased pages
//   high_wm        pend_cnt >= HIGH_WM
//   switch_fail    one-cycle pulse: a switch was rejected because the ring was full
// -----------------------------------------------------------------------------
module pp_ring #(
  parameter int N_WIDTH = 3,
  parameter int PAGE_AW = 8,
  parameter int HIGH_WM = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         wr_byte,
  input  logic [PAGE_AW-1:0] wr_addr,
  input  logic               wr_clk,
  input  logic [7:0]         wr_flags,
  input  logic               switch,
  input  logic               wr_abort,
  input  logic [PAGE_AW-1:0] rd_addr,
  output logic [7:0]         rd_byte,
  output logic [7:0]         rd_flags,
  output logic [PAGE_AW:0]   rd_len,
  input  logic               rd_done,
  input  logic               rd_done_all,
  output logic               unread,
  output logic [N_WIDTH-1:0] pend_cnt,
  output logic               high_wm,
  output logic               switch_fail
);

  localparam int N_PAGES   = 2 ** N_WIDTH;
  localparam int RAM_DEPTH = 2 ** (N_WIDTH + PAGE_AW);
  localparam int LEN_W     = PAGE_AW + 1;

  typedef logic [N_WIDTH-1:0] ptr_t;
  typedef logic [LEN_W-1:0]   len_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ptr_t       wr_ptr_q,      wr_ptr_d;
  ptr_t       rd_ptr_q,      rd_ptr_d;
  ptr_t       pend_cnt_q,    pend_cnt_d;
  len_t       wr_len_q,      wr_len_d;
  logic       unread_q,      unread_d;
  logic       high_wm_q,     high_wm_d;
  logic       switch_fail_q, switch_fail_d;
  logic [7:0] flags_q [N_PAGES];
  logic [7:0] flags_d [N_PAGES];
  len_t       len_q   [N_PAGES];
  len_t       len_d   [N_PAGES];

  logic [7:0] mem [RAM_DEPTH];

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  logic ring_full;
  len_t addr_plus1;
  len_t wr_len_grow;
  logic do_commit;
  logic do_release;

  assign ring_full  = (pend_cnt_q == ptr_t'(N_PAGES - 1));
  // One bit wider than the address so the last byte of a page yields 2**PAGE_AW.
  assign addr_plus1 = {1'b0, wr_addr} + len_t'(1);
  // Length as it would stand after this cycle's write, before abort/switch.
  assign wr_len_grow = (wr_clk && (addr_plus1 > wr_len_q)) ? addr_plus1 : wr_len_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pend_cnt_d    = pend_cnt_q;
    wr_len_d      = wr_len_grow;
    switch_fail_d = 1'b0;
    flags_d       = flags_q;
    len_d         = len_q;
    do_commit     = 1'b0;
    do_release    = 1'b0;

    if (rd_done_all) begin
      // Flush wins over everything else: the switched frame is dropped and
      // the write pointer stays where it is.
      rd_ptr_d   = wr_ptr_q;
      pend_cnt_d = '0;
      wr_len_d   = '0;
    end else begin
      do_release = rd_done && (pend_cnt_q != '0);

      if (wr_abort) begin
        wr_len_d = '0;
      end else if (switch) begin
        // A release in the same cycle frees a slot before the switch is judged.
        if (!ring_full || do_release) begin
          do_commit = 1'b1;
        end else begin
          switch_fail_d = 1'b1;
        end
        wr_len_d = '0;
      end

      if (do_commit) begin
        flags_d[wr_ptr_q] = wr_flags;
        len_d[wr_ptr_q]   = wr_len_grow;
        wr_ptr_d          = wr_ptr_q + ptr_t'(1);
      end

      if (do_release) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end

      case ({do_commit, do_release})
        2'b10:   pend_cnt_d = pend_cnt_q + ptr_t'(1);
        2'b01:   pend_cnt_d = pend_cnt_q - ptr_t'(1);
        default: pend_cnt_d = pend_cnt_q;
      endcase
    end

    unread_d  = (pend_cnt_d != '0);
    high_wm_d = (int'(pend_cnt_d) >= HIGH_WM);
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pend_cnt_q    <= '0;
      wr_len_q      <= '0;
      unread_q      <= 1'b0;
      high_wm_q     <= 1'b0;
      switch_fail_q <= 1'b0;
      for (int i = 0; i < N_PAGES; i++) begin
        flags_q[i] <= '0;
        len_q[i]   <= '0;
      end
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pend_cnt_q    <= pend_cnt_d;
      wr_len_q      <= wr_len_d;
      unread_q      <= unread_d;
      high_wm_q     <= high_wm_d;
      switch_fail_q <= switch_fail_d;
      flags_q       <= flags_d;
      len_q         <= len_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Page RAM
  // ---------------------------------------------------------------------------
  // NOTE: the RAM has no reset so it maps onto a plain memory macro; the
  // length registers already mark which bytes of a page are meaningful.
  always_ff @(posedge clk) begin
    if (wr_clk) begin
      mem[{wr_ptr_q, wr_addr}] <= wr_byte;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_byte     = mem[{rd_ptr_q, rd_addr}];
  assign rd_flags    = flags_q[rd_ptr_q];
  assign rd_len      = len_q[rd_ptr_q];
  assign unread      = unread_q;
  assign pend_cnt    = pend_cnt_q;
  assign high_wm     = high_wm_q;
  assign switch_fail = switch_fail_q;

endmodule

// File: tb/tb_pp_ring.sv
// -----------------------------------------------------------------------------
// tb_pp_ring -- self-checking bench for pp_ring.
//
// Two instances share all inputs: u_dut (8 pages, 256-byte pages, HIGH_WM=2)
// carries most of the checks, u_dut1 (2 pages) covers the two-page case.
// Committed frames are pushed onto a scoreboard queue and popped when the
// read side is examined. Control-path behaviour (pend_cnt, unread, high_wm,
// switch_fail) is driven from a table of per-cycle records.
// -----------------------------------------------------------------------------
module tb_pp_ring;

  localparam int PAGE_AW = 8;

  logic               clk;
  logic               reset_n;
  logic [7:0]         wr_byte;
  logic [PAGE_AW-1:0] wr_addr;
  logic               wr_clk;
  logic [7:0]         wr_flags;
  logic               switch;
  logic               wr_abort;
  logic [PAGE_AW-1:0] rd_addr;
  logic               rd_done;
  logic               rd_done_all;

  logic [7:0]         rd_byte,  rd_byte1;
  logic [7:0]         rd_flags, rd_flags1;
  logic [PAGE_AW:0]   rd_len,   rd_len1;
  logic               unread,   unread1;
  logic [2:0]         pend_cnt;
  logic [0:0]         pend_cnt1;
  logic               high_wm,  high_wm1;
  logic               switch_fail, switch_fail1;

  pp_ring #(.N_WIDTH(3), .PAGE_AW(PAGE_AW), .HIGH_WM(2)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .wr_byte(wr_byte), .wr_addr(wr_addr), .wr_clk(wr_clk), .wr_flags(wr_flags),
    .switch(switch), .wr_abort(wr_abort),
    .rd_addr(rd_addr), .rd_byte(rd_byte), .rd_flags(rd_flags), .rd_len(rd_len),
    .rd_done(rd_done), .rd_done_all(rd_done_all),
    .unread(unread), .pend_cnt(pend_cnt), .high_wm(high_wm), .switch_fail(switch_fail)
  );

  pp_ring #(.N_WIDTH(1), .PAGE_AW(PAGE_AW), .HIGH_WM(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .wr_byte(wr_byte), .wr_addr(wr_addr), .wr_clk(wr_clk), .wr_flags(wr_flags),
    .switch(switch), .wr_abort(wr_abort),
    .rd_addr(rd_addr), .rd_byte(rd_byte1), .rd_flags(rd_flags1), .rd_len(rd_len1),
    .rd_done(rd_done), .rd_done_all(rd_done_all),
    .unread(unread1), .pend_cnt(pend_cnt1), .high_wm(high_wm1), .switch_fail(switch_fail1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] flags;
    int         len;
    int         base;   // first byte address whose contents are checked
    logic [7:0] seed;
  } frame_t;

  frame_t sb[$];

  typedef struct {
    logic       sw;
    logic       rdn;
    logic       rda;
    logic       ab;
    int         exp_pend;
    logic       exp_unread;
    logic       exp_hwm;
    logic       exp_sfail;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [7:0] seed, input int i);
    return 8'(int'(seed) * (i + 1));
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input int addr, input logic [7:0] data);
    wr_addr = PAGE_AW'(addr);
    wr_byte = data;
    wr_clk  = 1'b1;
    step();
    wr_clk  = 1'b0;
  endtask

  task automatic write_data(input logic [7:0] seed, input int base, input int len);
    for (int i = base; i < len; i++) write_byte(i, byte_of(seed, i));
  endtask

  // Write a frame, switch it in, and record what the read side should show.
  task automatic commit(input logic [7:0] flags, input logic [7:0] seed, input int len);
    frame_t f;
    write_data(seed, 0, len);
    wr_flags = flags;
    switch   = 1'b1;
    step();
    switch   = 1'b0;
    f.flags = flags; f.len = len; f.base = 0; f.seed = seed;
    sb.push_back(f);
  endtask

  task automatic verify_head(input string tag);
    frame_t f;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    f = sb.pop_front();
    check({tag, "_flags"}, 32'(rd_flags), 32'(f.flags));
    check({tag, "_len"},   32'(rd_len),   32'(f.len));
    for (int i = f.base; i < f.len; i++) begin
      rd_addr = PAGE_AW'(i);
      #1;
      check($sformatf("%s_byte%0d", tag, i), 32'(rd_byte), 32'(byte_of(f.seed, i)));
    end
  endtask

  task automatic release_head();
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
  endtask

  task automatic check_ctrl(input string tag, input int pend, input logic un,
                            input logic hwm, input logic sfail);
    check({tag, "_pend"},   32'(pend_cnt),    32'(pend));
    check({tag, "_unread"}, 32'(unread),      32'(un));
    check({tag, "_hwm"},    32'(high_wm),     32'(hwm));
    check({tag, "_sfail"},  32'(switch_fail), 32'(sfail));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  vec_t vecs[12];

  initial begin
    frame_t f;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};  // switch
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0};  // switch, reach watermark
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};  // release
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};  // release last
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};  // release when empty: ignored
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};  // switch+release at 0: commit
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0};  // switch+abort: no commit
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0};  // switch
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0};  // switch+release: unchanged
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};  // flush beats everything
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};  // switch
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};  // flush alone

    reset_n = 1'b0; wr_byte = '0; wr_addr = '0; wr_clk = 1'b0; wr_flags = '0;
    switch = 1'b0; wr_abort = 1'b0; rd_addr = '0; rd_done = 1'b0; rd_done_all = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    step();

    // Reset state.
    check_ctrl("rst", 0, 1'b0, 1'b0, 1'b0);
    check("rst_flags", 32'(rd_flags), 32'h0);
    check("rst_len",   32'(rd_len),   32'h0);

    // Two-page ring: 0x11,0x22 then switch with flags 0x5A.
    commit(8'h5A, 8'h11, 2);
    rd_addr = '0;
    #1;
    check("n1_unread", 32'(unread1),      32'd1);
    check("n1_pend",   32'(pend_cnt1),    32'd1);
    check("n1_len",    32'(rd_len1),      32'd2);
    check("n1_flags",  32'(rd_flags1),    32'h5A);
    check("n1_byte0",  32'(rd_byte1),     32'h11);
    check("n1_hwm",    32'(high_wm1),     32'd1);
    check("n1_sfail",  32'(switch_fail1), 32'd0);
    verify_head("t1");
    release_head();
    check_ctrl("t1_after", 0, 1'b0, 1'b0, 1'b0);

    // Control-path table.
    for (int k = 0; k < 12; k++) begin
      switch      = vecs[k].sw;
      rd_done     = vecs[k].rdn;
      rd_done_all = vecs[k].rda;
      wr_abort    = vecs[k].ab;
      wr_flags    = 8'h00;
      step();
      switch = 1'b0; rd_done = 1'b0; rd_done_all = 1'b0; wr_abort = 1'b0;
      check_ctrl($sformatf("vec%0d", k), vecs[k].exp_pend, vecs[k].exp_unread,
                 vecs[k].exp_hwm, vecs[k].exp_sfail);
    end

    // Fill the 8-page ring, then one switch too many.
    for (int k = 0; k < 7; k++) commit(8'h80 + 8'(k), 8'h13 + 8'(k * 2), (k % 4) + 1);
    check_ctrl("full", 7, 1'b1, 1'b1, 1'b0);
    write_byte(0, 8'hEE);
    wr_flags = 8'hEE;
    switch   = 1'b1;
    step();
    switch   = 1'b0;
    check_ctrl("ovf", 7, 1'b1, 1'b1, 1'b1);
    step();
    check("ovf_pulse_end", 32'(switch_fail), 32'd0);
    check("ovf_head_flags", 32'(rd_flags), 32'(sb[0].flags));
    check("ovf_head_len",   32'(rd_len),   32'(sb[0].len));

    // Full ring: switch and release in the same cycle.
    verify_head("t3_head");
    write_data(8'h37, 0, 3);
    wr_flags = 8'hC3;
    switch   = 1'b1;
    rd_done  = 1'b1;
    step();
    switch   = 1'b0;
    rd_done  = 1'b0;
    f.flags = 8'hC3; f.len = 3; f.base = 0; f.seed = 8'h37;
    sb.push_back(f);
    check_ctrl("t3_swrd", 7, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      verify_head($sformatf("t3_drain%0d", k));
      release_head();
    end
    check_ctrl("t3_empty", 0, 1'b0, 1'b0, 1'b0);

    // Three pending, then flush together with a switch.
    for (int k = 0; k < 3; k++) commit(8'h40 + 8'(k), 8'h21 + 8'(k), 2);
    check_ctrl("t4_pre", 3, 1'b1, 1'b1, 1'b0);
    write_data(8'h55, 0, 2);
    wr_flags    = 8'h99;
    switch      = 1'b1;
    rd_done_all = 1'b1;
    step();
    switch      = 1'b0;
    rd_done_all = 1'b0;
    sb.delete();
    check_ctrl("t4_flush", 0, 1'b0, 1'b0, 1'b0);
    commit(8'h6B, 8'h29, 4);
    verify_head("t4_next");
    release_head();

    // Abort discards the length gathered so far.
    write_data(8'h0F, 0, 5);
    wr_abort = 1'b1;
    step();
    wr_abort = 1'b0;
    commit(8'h71, 8'h33, 2);
    check("t5_pend", 32'(pend_cnt), 32'd1);
    verify_head("t5_abort");
    release_head();

    // Last byte of the page alone gives a full-page length.
    write_byte(255, byte_of(8'h45, 255));
    wr_flags = 8'hF0;
    switch   = 1'b1;
    step();
    switch   = 1'b0;
    f.flags = 8'hF0; f.len = 256; f.base = 255; f.seed = 8'h45;
    sb.push_back(f);
    verify_head("t5_full");
    release_head();

    // Reset in the middle of a write with two frames pending.
    commit(8'hA1, 8'h17, 2);
    commit(8'hA2, 8'h19, 3);
    check("t6_pre_pend", 32'(pend_cnt), 32'd2);
    wr_addr = 8'h01;
    wr_byte = 8'hBB;
    wr_clk  = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check_ctrl("t6_in_rst", 0, 1'b0, 1'b0, 1'b0);
    wr_clk = 1'b0;
    step();
    reset_n = 1'b1;
    sb.delete();
    step();
    check_ctrl("t6_post", 0, 1'b0, 1'b0, 1'b0);
    check("t6_flags", 32'(rd_flags), 32'h0);
    check("t6_len",   32'(rd_len),   32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
